fifo_rd_scheduler: RTL
======================

Name: fifo_rd_scheduler

Overview:
Round-robin read scheduler that drains NUM_PORTS simple FIFOs (show-ahead data, registered empty flag) into one valid/ready output stream. Grants one FIFO at a time for a burst of up to burst_len beats. Ends the burst early if that FIFO runs empty, then rotates to the next non-empty FIFO. Sits between the per-requester FIFOs and the shared downstream consumer.

Parameters:
NUM_PORTS, 4, number of FIFOs served (>=2)
WIDTH, 8, data width, equal to FIFO WIDTH
MAX_BURST, 8, maximum beats per grant
PORT_W, $clog2(NUM_PORTS), derived port-index width
BL_W, $clog2(MAX_BURST+1), derived burst_len width

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  reset, asynchronous, active-high
enable  in  1  1 = scheduling allowed
burst_len  in  BL_W  beats per grant, sampled at grant; 0 treated as 1; >MAX_BURST clamped to MAX_BURST
fifo_empty  in  NUM_PORTS  per-FIFO empty flag
fifo_data  in  NUM_PORTS x WIDTH (packed [NUM_PORTS-1:0][WIDTH-1:0])  per-FIFO head data, valid while !fifo_empty
fifo_rd  out  NUM_PORTS  per-FIFO pop strobe, at most one bit high
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_data  out  WIDTH  output beat data
out_port  out  PORT_W  source FIFO index of out_data
busy  out  1  state != IDLE or out_valid

Behaviour:
- Reset (async assert, sync release by upstream)
  - state=IDLE, grant=0, last_grant=NUM_PORTS-1 (port 0 wins first), beat_cnt=0.
  - out_valid=0, out_data=0, out_port=0, fifo_rd=0, busy=0.
- States:
  - IDLE: if enable and any !fifo_empty, select the first non-empty port searching from last_grant+1 upward with wrap-around. Register grant and burst target, go to BURST. Otherwise stay. fifo_rd=0 in IDLE; one bubble cycle per grant.
  - BURST
    - pop_ok = !fifo_empty[grant] && (!out_valid || out_ready).
    - fifo_rd[grant] = pop_ok && enable (combinational).
    - On a pop: out_data <= fifo_data[grant], out_port <= grant, out_valid <= 1, beat_cnt++.
    - Exit to IDLE, with last_grant <= grant, when either:
      - the pop is beat number burst_len; or
      - fifo_empty[grant]=1 while !out_valid || out_ready; or
      - enable=0.
    - Exit on enable=0 performs no pop that cycle. beat_cnt clears on exit.
- Output stage
  - Single register: out_valid set on a pop.
  - out_valid cleared on out_ready with no pop that cycle.
  - out_data and out_port stable while out_valid && !out_ready.
  - Sustained throughput 1 beat/cycle inside a burst.
- fifo_empty handling: the FIFO empty flag may lag a write by one cycle but never lags a read. The scheduler trusts fifo_empty every cycle and never pops an empty FIFO.
- Boundaries:
  - Only the granted FIFO is non-empty: it is re-granted after one IDLE cycle.
  - A FIFO filled mid-burst of another port waits its turn.
  - out_ready low stalls the burst without consuming beats.
  - enable low still lets out_valid drain.
  - busy is registered-state based.
- Reset mid-burst: immediate abort. fifo_rd drops asynchronously, held output beat lost, FIFOs reset by their own logic.

Decomposition:
- Package fifo_sched_pkg:
  - sched_state_t enum {IDLE, BURST}.
  - Function rr_next(req, last) returning the next index.
  - Function clamp_burst(len, max).
- Sub-module fifo_rr_pick: combinational round-robin picker.
  - Inputs req[NUM_PORTS], last[PORT_W]; outputs any, idx[PORT_W].
  - Unit-tested standalone.

Test Plan:
- Reset then idle: rst pulse, all fifo_empty=1 -> out_valid=0, fifo_rd=0, busy=0 for 20 cycles.
- Burst limit: NUM_PORTS=4, burst_len=3, FIFO0 holds 0x10..0x15, FIFO1 holds 0xA0..0xA1, out_ready=1 -> output sequence 10,11,12 (port0), A0,A1 (port1), 13,14,15 (port0), one bubble between bursts.
- Early empty and rotation: burst_len=8, FIFOs 0..3 each hold 1 beat (0x00,0x11,0x22,0x33) -> out_port order 0,1,2,3, exactly 4 beats, no pop of an empty FIFO.
- Backpressure: out_ready toggled 1,0,0,1 during a port-2 burst of 0x5A,0x5B -> out_data holds 0x5A through stall, no fifo_rd while out_valid && !out_ready, no loss or duplicate.
- Edge config: burst_len=0 -> one beat per grant. burst_len=15 with MAX_BURST=8 -> max 8 beats. enable dropped mid-burst -> no further fifo_rd, pending out beat still delivered.
- Async reset mid-burst: assert rst between clock edges during port-1 burst -> fifo_rd=0 and out_valid=0 immediately. After release, the first grant goes to port 0.

Source files
------------

// File: rtl/fifo_rd_scheduler_pkg.sv
// Shared types and helpers for the round-robin FIFO read scheduler.
package fifo_sched_pkg;

  localparam int MAX_PORTS   = 32;
  localparam int MAX_PORT_W  = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_t;

  // First requesting index after 'last', wrapping at num_ports; 'last' if none request.
  function automatic int rr_next(input logic [MAX_PORTS-1:0] req,
                                 input int last,
                                 input int num_ports);
    int idx;
    rr_next = last;
    for (int k = MAX_PORTS; k >= 1; k--) begin
      if (k <= num_ports) begin
        idx = (last + k) % num_ports;
        if (req[idx[MAX_PORT_W-1:0]]) begin
          rr_next = idx;
        end
      end
    end
  endfunction

  function automatic int clamp_burst(input int len, input int max_len);
    if (len <= 0) begin
      return 1;
    end
    if (len > max_len) begin
      return max_len;
    end
    return len;
  endfunction

endpackage

// File: rtl/fifo_rd_scheduler_if.sv
// FIFO-side and stream-side signals of the read scheduler.
interface fifo_rd_scheduler_if #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 8,
  parameter int PORT_W    = $clog2(NUM_PORTS)
);

  logic [NUM_PORTS-1:0]            fifo_empty;
  logic [NUM_PORTS-1:0][WIDTH-1:0] fifo_data;
  logic [NUM_PORTS-1:0]            fifo_rd;
  logic                            out_valid;
  logic                            out_ready;
  logic [WIDTH-1:0]                out_data;
  logic [PORT_W-1:0]               out_port;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_rd, out_valid, out_data, out_port
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_rd, out_valid, out_data, out_port
  );

endinterface

// File: rtl/fifo_rd_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module fifo_rr_pick
  import fifo_sched_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last,
  output logic                 any,
  output logic [PORT_W-1:0]    idx
);

  logic [MAX_PORTS-1:0] req_pad;

  generate
    for (genvar gi = 0; gi < MAX_PORTS; gi++) begin : g_pad
      if (gi < NUM_PORTS) begin : g_used
        assign req_pad[gi] = req[gi];
      end else begin : g_unused
        assign req_pad[gi] = 1'b0;
      end
    end
  endgenerate

  assign any = |req;
  assign idx = PORT_W'(rr_next(req_pad, int'(last), NUM_PORTS));

endmodule

// File: rtl/fifo_rd_scheduler.sv
// Round-robin burst scheduler draining NUM_PORTS show-ahead FIFOs into one valid/ready stream.
module fifo_rd_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 8,
  parameter int PORT_W    = $clog2(NUM_PORTS),
  parameter int BL_W      = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [BL_W-1:0]   burst_len,
  fifo_rd_scheduler_if.master bus,
  output logic              busy
);

  sched_state_t      state_reg, state_next;
  logic [PORT_W-1:0] grant_reg, grant_next;
  logic [PORT_W-1:0] last_grant_reg, last_grant_next;
  logic [BL_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [BL_W-1:0]   target_reg, target_next;
  logic              out_valid_reg, out_valid_next;
  logic [WIDTH-1:0]  out_data_reg, out_data_next;
  logic [PORT_W-1:0] out_port_reg, out_port_next;

  logic [NUM_PORTS-1:0] req;
  logic                 pick_any;
  logic [PORT_W-1:0]    pick_idx;
  logic                 head_empty;
  logic                 can_accept;
  logic                 pop;
  logic                 last_beat;
  logic                 burst_end;

  assign req = ~bus.fifo_empty;

  fifo_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .req  (req),
    .last (last_grant_reg),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // The output register can take a new beat when empty or being drained this cycle.
  assign head_empty = bus.fifo_empty[grant_reg];
  assign can_accept = !out_valid_reg || bus.out_ready;
  assign pop        = (state_reg == BURST) && enable && !head_empty && can_accept;
  assign last_beat  = (beat_cnt_reg + BL_W'(1)) == target_reg;
  assign burst_end  = !enable || (head_empty && can_accept) || (pop && last_beat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= PORT_W'(NUM_PORTS - 1);
      beat_cnt_reg   <= '0;
      target_reg     <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_port_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
      target_reg     <= target_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      out_port_reg   <= out_port_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    target_next     = target_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    out_port_next   = out_port_reg;

    case (state_reg)
      IDLE: begin
        if (enable && pick_any) begin
          state_next    = BURST;
          grant_next    = pick_idx;
          target_next   = BL_W'(clamp_burst(int'(burst_len), MAX_BURST));
          beat_cnt_next = '0;
        end
      end
      BURST: begin
        if (pop) begin
          beat_cnt_next = beat_cnt_reg + BL_W'(1);
        end
        if (burst_end) begin
          state_next      = IDLE;
          last_grant_next = grant_reg;
          beat_cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (pop) begin
      out_valid_next = 1'b1;
      out_data_next  = bus.fifo_data[grant_reg];
      out_port_next  = grant_reg;
    end else if (bus.out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_comb begin
    bus.fifo_rd = '0;
    if (pop) begin
      bus.fifo_rd[grant_reg] = 1'b1;
    end
    bus.out_valid = out_valid_reg;
    bus.out_data  = out_data_reg;
    bus.out_port  = out_port_reg;
    busy          = (state_reg != IDLE) || out_valid_reg;
  end

endmodule
